// File: rtl/sr_latch_driver.sv
// ---------------------------------------------------------------------------
// sr_latch_driver : non-overlapping fixed-width S/R pulse driver with readback
// Optional macro  : SR_SKIP_REDUNDANT_EN (skip pulse when latch already there)
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sr_latch_driver #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  input  logic q,
  input  logic qbar,
  output logic s,
  output logic r,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int c_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int c_CW  = $clog2(c_MAX + 1);
  localparam logic [c_CW-1:0] c_PULSE_LD = c_CW'(PULSE_W - 1);
  localparam logic [c_CW-1:0] c_GAP_LD   = c_CW'(GAP_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_CW-1:0] r_cnt, w_cnt_nxt;
  logic            r_op_set, w_op_set_nxt;
  logic            r_s, r_r, r_busy, r_done, r_err;
  logic            w_s_nxt, w_r_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
  logic            w_set_ok, w_clr_ok, w_target_ok;

  assign w_set_ok    = q & ~qbar;
  assign w_clr_ok    = ~q & qbar;
  assign w_target_ok = r_op_set ? w_set_ok : w_clr_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op_set <= 1'b0;
      r_s      <= 1'b0;
      r_r      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op_set <= w_op_set_nxt;
      r_s      <= w_s_nxt;
      r_r      <= w_r_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // s and r both derive from the single op bit, so they can never overlap.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_op_set_nxt = r_op_set;
    w_s_nxt      = 1'b0;
    w_r_nxt      = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (set_req && clr_req) begin
          w_err_nxt = 1'b1;
`ifdef SR_SKIP_REDUNDANT_EN
        end else if ((set_req && w_set_ok) || (clr_req && w_clr_ok)) begin
          w_done_nxt = 1'b1;
`endif
        end else if (set_req || clr_req) begin
          w_state_nxt  = ST_PULSE;
          w_cnt_nxt    = c_PULSE_LD;
          w_op_set_nxt = set_req;
          w_s_nxt      = set_req;
          w_r_nxt      = clr_req;
          w_busy_nxt   = 1'b1;
        end
      end
      ST_PULSE: begin
        w_busy_nxt = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = c_GAP_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          w_s_nxt   = r_op_set;
          w_r_nxt   = ~r_op_set;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = ~w_target_ok;
        end else begin
          w_cnt_nxt  = r_cnt - 1'b1;
          w_busy_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign s    = r_s;
  assign r    = r_r;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
// ---------------------------------------------------------------------------
// tb_sr_latch_driver : scoreboard bench for sr_latch_driver with a model latch
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst_n, set_req, clr_req;
  logic s, r, busy, done, err;
  logic q_lat = 1'b0;
  logic fault = 1'b0;
  logic q, qbar;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    bit d;
    bit e;
    int c;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model latch; fault ties both outputs low.
  always @(posedge clk) begin
    if (s === 1'b1) q_lat <= 1'b1;
    else if (r === 1'b1) q_lat <= 1'b0;
  end
  assign q    = fault ? 1'b0 : q_lat;
  assign qbar = fault ? 1'b0 : ~q_lat;

  sr_latch_driver #(.PULSE_W(4), .GAP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
    .q(q), .qbar(qbar), .s(s), .r(r), .busy(busy), .done(done), .err(err)
  );

  always @(negedge clk) begin
    exp_t e;
    if (s === 1'b1 && r === 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL overlap: s=1 and r=1 at cycle %0d (required never)", cyc);
    end
    if (rst_n === 1'b1 && (done === 1'b1 || err === 1'b1)) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: done=%b err=%b at cycle %0d, required none", done, err, cyc);
      end else begin
        e = sbq.pop_front();
        if (done !== e.d || err !== e.e || cyc != e.c) begin
          n_fail++;
          $display("FAIL strobe: got done=%b err=%b cyc=%0d, required done=%b err=%b cyc=%0d",
                   done, err, cyc, e.d, e.e, e.c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: {s,r,busy}/{..} got %b required %b at cycle %0d", name, got, want, cyc);
    end
  endtask

  // One full operation: checks s/r/busy per cycle; optional busy request at E0+2.
  task automatic do_op(input bit is_set, input bit exp_err, input bit inject_busy);
    exp_t e;
    @(negedge clk);
    e.d = 1'b1; e.e = exp_err; e.c = cyc + 7;
    sbq.push_back(e);
    set_req = is_set; clr_req = ~is_set;
    @(negedge clk);
    set_req = 1'b0; clr_req = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      chk(is_set ? "set_pulse" : "clr_pulse", {s, r, busy},
          {is_set && (i < 4), !is_set && (i < 4), i < 6});
      if (inject_busy && i == 1) set_req = 1'b1;
      if (inject_busy && i == 2) set_req = 1'b0;
      if (i < 6) @(negedge clk);
    end
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; set_req = 1'b0; clr_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_sr_busy", {s, r, busy}, 3'b000);
    chk("reset_done_err", {1'b0, done, err}, 3'b000);
    rst_n = 1'b1;

    do_op(1'b1, 1'b0, 1'b0);
    chk("q_after_set", {1'b0, q, qbar}, 3'b010);
    do_op(1'b0, 1'b0, 1'b0);
    chk("q_after_clr", {1'b0, q, qbar}, 3'b001);
    do_op(1'b1, 1'b0, 1'b0);

    // Redundant set with q already 1.
`ifdef SR_SKIP_REDUNDANT_EN
    @(negedge clk);
    e.d = 1'b1; e.e = 1'b0; e.c = cyc + 1;
    sbq.push_back(e);
    set_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("skip_no_pulse", {s, r, busy}, 3'b000);
      @(negedge clk);
    end
`else
    do_op(1'b1, 1'b0, 1'b0);
`endif

    // Conflict request.
    @(negedge clk);
    e.d = 1'b0; e.e = 1'b1; e.c = cyc + 1;
    sbq.push_back(e);
    set_req = 1'b1; clr_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0; clr_req = 1'b0;
    chk("conflict_idle", {s, r, busy}, 3'b000);
    @(negedge clk);
    chk("conflict_after", {s, r, busy}, 3'b000);

    // Faulted readback plus ignored request while busy.
    fault = 1'b1;
    do_op(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("busy_req_ignored", {s, r, busy}, 3'b000);
    fault = 1'b0;

    // Reset mid-pulse: no strobe may follow.
    @(negedge clk);
    set_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
    chk("midrst_pulse_on", {s, r, busy}, 3'b101);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_cut", {s, r, busy}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_quiet", {s, r, busy}, 3'b000);

    do_op(1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected strobes never seen, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
